// File: rtl/regfile_pkg.sv
// Shared types and constants for the scoreboarded register file.
//   REG_AW     : default register address width for the default register count
//   reg_addr_t : register index type at the default width
//   xlen_t     : register data type at the default width
//   ZERO_REG   : index of the hard-wired zero register
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned NREAD_DEF = 2;
    localparam int unsigned REG_AW    = $clog2(NREGS_DEF);

    typedef logic [REG_AW-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/reg_busy_table.sv
// Per-register busy scoreboard.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset, clears every busy bit
//   set_en   : reserve set_idx (issue); wins over a clear of the same index
//   set_idx  : register reserved by issue
//   clr_en   : release clr_idx (writeback)
//   clr_idx  : register released by writeback
//   busy     : current busy bit per register (bit 0 always 0)
//   any_busy : OR of all busy bits
module reg_busy_table
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_en,
    input  logic [$clog2(NREGS)-1:0] set_idx,
    input  logic                     clr_en,
    input  logic [$clog2(NREGS)-1:0] clr_idx,
    output logic [NREGS-1:0]         busy,
    output logic                     any_busy
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        // Clear first so that a same-cycle issue to the same register wins.
        if (clr_en && (clr_idx != AW'(ZERO_REG))) begin
            busy_d[clr_idx] = 1'b0;
        end
        if (set_en && (set_idx != AW'(ZERO_REG))) begin
            busy_d[set_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign any_busy = |busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port integer register file with a per-register busy scoreboard.
// Register 0 reads as zero and is never busy.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (clears data and busy bits)
//   ra        : NREAD read addresses
//   rd_data   : NREAD combinational read data
//   rd_busy   : NREAD busy flags (operand not ready)
//   we/wa/wd  : writeback enable, address, data (clears busy)
//   iss_valid : issue strobe, reserves iss_rd (sets busy)
//   iss_rd    : issued destination register
//   any_busy  : OR of all busy bits
// Configuration macro: REGFILE_BYPASS_EN enables write-through forwarding of
// wd to read ports whose address matches wa in the write cycle.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NREAD = NREAD_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NREAD-1:0][$clog2(NREGS)-1:0] ra,
    output logic [NREAD-1:0][XLEN-1:0]          rd_data,
    output logic [NREAD-1:0]                    rd_busy,
    input  logic                                we,
    input  logic [$clog2(NREGS)-1:0]            wa,
    input  logic [XLEN-1:0]                     wd,
    input  logic                                iss_valid,
    input  logic [$clog2(NREGS)-1:0]            iss_rd,
    output logic                                any_busy
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy;
    logic             wr_en;

    assign wr_en = we && (wa != AW'(ZERO_REG));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wa] <= wd;
        end
    end

    reg_busy_table #(
        .NREGS (NREGS)
    ) u_busy_table (
        .clk      (clk),
        .rst      (rst),
        .set_en   (iss_valid),
        .set_idx  (iss_rd),
        .clr_en   (we),
        .clr_idx  (wa),
        .busy     (busy),
        .any_busy (any_busy)
    );

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NREAD; p++) begin
            if (ra[p] != AW'(ZERO_REG)) begin
                rd_data[p] = regs_q[ra[p]];
                rd_busy[p] = busy[ra[p]];
`ifdef REGFILE_BYPASS_EN
                // Forward the writeback in flight; wr_en already excludes register 0.
                if (wr_en && (wa == ra[p])) begin
                    rd_data[p] = wd;
                    rd_busy[p] = 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    logic             clk;
    logic             rst;
    logic [1:0][4:0]  ra;
    logic [1:0][31:0] rd_data;
    logic [1:0]       rd_busy;
    logic             we;
    logic [4:0]       wa;
    logic [31:0]      wd;
    logic             iss_valid;
    logic [4:0]       iss_rd;
    logic             any_busy;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard #(
        .XLEN  (32),
        .NREGS (32),
        .NREAD (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ra        (ra),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .any_busy  (any_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge; inputs are changed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we        = 1'b0;
        wa        = '0;
        wd        = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        ra = '0;
        step();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ra[0] = 5'(a);
            ra[1] = 5'(31 - a);
            #1;
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (rd_data[p] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_data addr=%0d port=%0d got %h want 0", a, p, rd_data[p]);
                end
                checks++;
                if (rd_busy[p] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_busy addr=%0d port=%0d got %b want 0", a, p, rd_busy[p]);
                end
            end
        end
        checks++;
        if (any_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_any_busy got %b want 0", any_busy);
        end
    endtask

    task automatic test_write();
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        step();
        idle_inputs();
        ra[0] = 5'd5;
        #1;
        checks++;
        if (rd_data[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_data got %h want deadbeef", rd_data[0]);
        end
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL write_busy got %b want 0", rd_busy[0]);
        end
    endtask

    task automatic test_reg_zero();
        we = 1'b1; wa = 5'd0; wd = 32'h1234;
        iss_valid = 1'b1; iss_rd = 5'd0;
        step();
        idle_inputs();
        ra[0] = 5'd0;
        ra[1] = 5'd0;
        #1;
        checks++;
        if (rd_data[0] !== 32'h0) begin
            errors++;
            $display("FAIL zero_data got %h want 0", rd_data[0]);
        end
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_busy got %b want 0", rd_busy[0]);
        end
        checks++;
        if (any_busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_any_busy got %b want 0", any_busy);
        end
    endtask

    task automatic test_issue_then_write();
        iss_valid = 1'b1; iss_rd = 5'd7;
        step();
        idle_inputs();
        ra[1] = 5'd7;
        #1;
        checks++;
        if (rd_busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL issue_busy got %b want 1", rd_busy[1]);
        end
        checks++;
        if (any_busy !== 1'b1) begin
            errors++;
            $display("FAIL issue_any_busy got %b want 1", any_busy);
        end
        we = 1'b1; wa = 5'd7; wd = 32'h55;
        step();
        idle_inputs();
        #1;
        checks++;
        if (rd_busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL wb_busy got %b want 0", rd_busy[1]);
        end
        checks++;
        if (rd_data[1] !== 32'h55) begin
            errors++;
            $display("FAIL wb_data got %h want 55", rd_data[1]);
        end
        checks++;
        if (any_busy !== 1'b0) begin
            errors++;
            $display("FAIL wb_any_busy got %b want 0", any_busy);
        end
    endtask

    task automatic test_issue_write_same();
        iss_valid = 1'b1; iss_rd = 5'd9;
        we = 1'b1; wa = 5'd9; wd = 32'hA5;
        step();
        idle_inputs();
        ra[0] = 5'd9;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_busy got %b want 1", rd_busy[0]);
        end
        checks++;
        if (rd_data[0] !== 32'hA5) begin
            errors++;
            $display("FAIL same_cycle_data got %h want a5", rd_data[0]);
        end
    endtask

    task automatic test_bypass_and_reset();
        logic [31:0] exp_same;
        // Reserve register 3 so the busy bit in the write cycle is observable.
        iss_valid = 1'b1; iss_rd = 5'd3;
        step();
        idle_inputs();
        ra[0] = 5'd3;
        ra[1] = 5'd3;
        we = 1'b1; wa = 5'd3; wd = 32'h77;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h77;
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL bypass_busy got %b want 0", rd_busy[0]);
        end
`else
        exp_same = 32'h0;
        checks++;
        if (rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL nobypass_busy got %b want 1", rd_busy[0]);
        end
`endif
        checks++;
        if (rd_data[0] !== exp_same) begin
            errors++;
            $display("FAIL write_cycle_data got %h want %h", rd_data[0], exp_same);
        end
        step();
        idle_inputs();
        #1;
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (rd_data[p] !== 32'h77) begin
                errors++;
                $display("FAIL next_cycle_data port=%0d got %h want 77", p, rd_data[p]);
            end
        end
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL next_cycle_busy got %b want 0", rd_busy[0]);
        end
        // Register 9 is still busy; add a reservation and try a write under reset.
        iss_valid = 1'b1; iss_rd = 5'd12;
        step();
        checks++;
        if (any_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_any_busy got %b want 1", any_busy);
        end
        rst = 1'b1;
        we = 1'b1; wa = 5'd4; wd = 32'h99;
        iss_valid = 1'b1; iss_rd = 5'd4;
        step();
        rst = 1'b0;
        idle_inputs();
        checks++;
        if (any_busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_any_busy got %b want 0", any_busy);
        end
        ra[0] = 5'd9;
        ra[1] = 5'd4;
        #1;
        checks++;
        if (rd_data[0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_r9 got %h/%b want 0/0", rd_data[0], rd_busy[0]);
        end
        checks++;
        if (rd_data[1] !== 32'h0 || rd_busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_r4 got %h/%b want 0/0", rd_data[1], rd_busy[1]);
        end
        ra[0] = 5'd5;
        ra[1] = 5'd3;
        #1;
        checks++;
        if (rd_data[0] !== 32'h0 || rd_data[1] !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_data got %h %h want 0 0", rd_data[0], rd_data[1]);
        end
    endtask

    initial begin
        rst = 1'b1;
        ra  = '0;
        idle_inputs();
        test_reset();
        test_write();
        test_reg_zero();
        test_issue_then_write();
        test_issue_write_same();
        test_bypass_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
